bmu_soft_pipe: RTL and testbench
================================

// Module: bmu_soft_pipe
// PURPOSE
//  Parametrised soft-decision branch metric unit (BMU) for the Viterbi decoder.
//  Accepts one received symbol per handshake: N_OUT soft values of SOFT_W bits each.
//  Emits the branch metrics for all 2**N_OUT candidate codewords through a 2-stage valid/ready pipeline.
//  Feeds the ACS array and replaces the per-codeword hard-decision bmc blocks.
//  SOFT_W=1 reproduces the hard-decision Hamming metric.
// PARAMETERS
//  N_OUT   2  code outputs per trellis step (1/N_OUT rate); legal range 2..4
//  SOFT_W  3  soft bits per value; 0 = confident '0', SMAX=2**SOFT_W-1 = confident '1'
//  CNT_W   16 width of the per-frame symbol counter
//  BM_W    (derived) SOFT_W+$clog2(N_OUT); worst-case metric N_OUT*SMAX fits, no saturation
// PORTS
//  clk        in   1                  clock, rising edge
//  rst_n      in   1                  asynchronous reset, active low
//  in_valid   in   1                  symbol valid
//  in_ready   out  1                  BMU can accept a symbol
//  in_sym     in   N_OUT*SOFT_W       soft value i at [i*SOFT_W +: SOFT_W]
//  in_last    in   1                  last symbol of the frame
//  in_erase   in   N_OUT              punctured/erased mask; present only with BMU_ERASURE_EN
//  out_valid  out  1                  metrics valid
//  out_ready  in   1                  ACS accepts the metrics
//  out_bm     out  (2**N_OUT)*BM_W    metric for codeword c at [c*BM_W +: BM_W]
//  out_last   out  1                  in_last, aligned with out_bm
//  sym_cnt    out  CNT_W              symbols accepted in the current frame
// BEHAVIOUR
//  - Clock is clk. Reset is rst_n: asynchronous, active low.
//  - Reset values: out_valid=0, out_bm=0, out_last=0, sym_cnt=0, all stage valids=0.
//    in_ready=1 after reset.
//  - Metric: bm[c] = sum over i of (c[i] ? SMAX-r_i : r_i). Sums are unsigned at BM_W bits.
//  - Stage 1 registers, per bit, d0_i=r_i and d1_i=SMAX-r_i, plus last.
//    Stage 2 registers the 2**N_OUT adder trees into out_bm and out_last.
//  - Latency: 2 cycles from the in_valid&&in_ready accept to out_valid, when not stalled.
//    Throughput: 1 symbol/cycle.
//  - Handshake: a stage advances when it is empty or its downstream stage advances.
//    in_ready = !s1_valid || s1_adv, where s1_adv = !out_valid || out_ready.
//    in_ready has no combinational path from in_valid.
//  - While out_valid=1 and out_ready=0, out_bm and out_last hold stable.
//    With both stages full, in_ready=0.
//  - Transfers: an input transfer is in_valid&&in_ready. An output transfer is out_valid&&out_ready.
//  - sym_cnt: on each input transfer, sym_cnt becomes 0 if in_last=1, else sym_cnt+1.
//    sym_cnt wraps modulo 2**CNT_W; there is no error flag.
//  - in_valid=1 with in_ready=0: input is ignored and the counter is unchanged.
//    The source must hold in_sym and in_last stable.
//  - Reset mid-frame: in-flight symbols are discarded and sym_cnt returns to 0 asynchronously.
//  - Simultaneous input and output transfers on a full pipeline: both occur and occupancy stays 2.
// CONFIGURATION
//  - BMU_ERASURE_EN defined: port in_erase exists and is registered with the symbol in stage 1.
//    An erased bit i contributes 0 to every bm[c] (forces d0_i=d1_i=0).
//    All-ones erase gives bm[c]=0 for all c.
//  - BMU_ERASURE_EN undefined: port in_erase is absent, there is no erase logic, and every bit contributes.
// STRUCTURE
//  - Shared package vit_pkg:
//    function bm_width(n_out,soft_w) returning soft_w+$clog2(n_out);
//    function smax(soft_w);
//    localparam defaults N_OUT_DEF=2, SOFT_W_DEF=3.
//  - Sub-module bmu_dist_lane, one per code bit, instantiated N_OUT times.
//    Inputs: r_i, erase_i. Outputs: d0_i, d1_i (combinational).
//    The top level owns the pipeline registers, the adder trees, the handshake and the counter.
// TESTING (N_OUT=2, SOFT_W=3 unless noted; r = {r1,r0})
//  1. Reset, then r={7,0}, out_ready=1 -> after 2 cycles out_bm[0..3]={7,14,0,7}; sym_cnt=1.
//  2. SOFT_W=1 build, r={1,0} -> bm[0..3]={1,2,0,1}; matches the hard-decision bmc result.
//  3. Stream of 8 symbols, out_ready low for cycles 3-5:
//     out_bm held stable, in_ready=0 once both stages are full, no loss or duplication, order kept.
//  4. in_last on the 5th symbol -> out_last set on the 5th output; sym_cnt goes to 0, then counts 1 on the next symbol.
//  5. BMU_ERASURE_EN, r={7,0}, erase=2'b10 -> bm[0..3]={0,7,0,7}; erase=2'b11 -> all 0.
//  6. rst_n asserted asynchronously mid-stream with 2 symbols in flight
//     -> out_valid=0 and sym_cnt=0 immediately; no stale output after release.

Source files
------------

// File: rtl/vit_pkg.sv
// Shared Viterbi decoder definitions.
// Metric width and soft-value helpers.
package vit_pkg;

  localparam int N_OUT_DEF  = 2;
  localparam int SOFT_W_DEF = 3;

  function automatic int bm_width(
    input int n_out,
    input int soft_w
  );
    return soft_w + $clog2(n_out);
  endfunction

  function automatic int smax(
    input int soft_w
  );
    return (1 << soft_w) - 1;
  endfunction

endpackage

// File: rtl/bmu_soft_pipe_if.sv
// Symbol-in / metrics-out handshake bundle.
// in_erase exists only when BMU_ERASURE_EN is defined.
interface bmu_soft_pipe_if
  import vit_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SOFT_W = SOFT_W_DEF
);
  localparam int BM_W = bm_width(N_OUT, SOFT_W);
  localparam int NC   = 2 ** N_OUT;

  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*SOFT_W-1:0] in_sym;
  logic                    in_last;
`ifdef BMU_ERASURE_EN
  logic [N_OUT-1:0]        in_erase;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic [NC*BM_W-1:0]      out_bm;
  logic                    out_last;

`ifdef BMU_ERASURE_EN
  modport master (
    output in_valid, in_sym, in_last,
    output in_erase, out_ready,
    input  in_ready, out_valid,
    input  out_bm, out_last
  );
  modport slave (
    input  in_valid, in_sym, in_last,
    input  in_erase, out_ready,
    output in_ready, out_valid,
    output out_bm, out_last
  );
`else
  modport master (
    output in_valid, in_sym, in_last,
    output out_ready,
    input  in_ready, out_valid,
    input  out_bm, out_last
  );
  modport slave (
    input  in_valid, in_sym, in_last,
    input  out_ready,
    output in_ready, out_valid,
    output out_bm, out_last
  );
`endif

endinterface

// File: rtl/bmu_dist_lane.sv
// Per-code-bit distances to '0' and '1'.
// Erased bits contribute nothing.
module bmu_dist_lane
  import vit_pkg::*;
#(
  parameter int SOFT_W = SOFT_W_DEF
) (
  input  logic [SOFT_W-1:0] r_i,
  input  logic              erase_i,
  output logic [SOFT_W-1:0] d0_i,
  output logic [SOFT_W-1:0] d1_i
);
  localparam logic [SOFT_W-1:0] SMAX =
    SOFT_W'(smax(SOFT_W));

  assign d0_i = erase_i ? '0 : r_i;
  assign d1_i = erase_i ? '0 : SMAX - r_i;

endmodule

// File: rtl/bmu_soft_pipe.sv
// Soft-decision branch metric unit, 2-stage pipe.
// Optional erasure input: define BMU_ERASURE_EN.
module bmu_soft_pipe
  import vit_pkg::*;
#(
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SOFT_W = SOFT_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bmu_soft_pipe_if.slave   bus,
  output logic [CNT_W-1:0] sym_cnt
);
  localparam int BM_W = bm_width(N_OUT, SOFT_W);
  localparam int NC   = 2 ** N_OUT;

  typedef logic [N_OUT-1:0][SOFT_W-1:0] dvec_t;

  dvec_t              d0, d1;
  dvec_t              s1_d0, s1_d1;
  logic [N_OUT-1:0]   er;
  logic               s1_valid, s1_last;
  logic               s1_adv, in_ready, in_xfer;
  logic               o_valid, o_last;
  logic [NC*BM_W-1:0] o_bm, bm_sum;
  logic [BM_W-1:0]    acc;

`ifdef BMU_ERASURE_EN
  assign er = bus.in_erase;
`else
  assign er = '0;
`endif

  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    bmu_dist_lane #(.SOFT_W(SOFT_W)) u_lane (
      .r_i     (bus.in_sym[i*SOFT_W +: SOFT_W]),
      .erase_i (er[i]),
      .d0_i    (d0[i]),
      .d1_i    (d1[i])
    );
  end

  assign s1_adv   = !o_valid || bus.out_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign in_xfer  = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = o_valid;
  assign bus.out_bm    = o_bm;
  assign bus.out_last  = o_last;

  // adder tree per codeword: pick d1 where codeword bit is 1
  always_comb begin
    bm_sum = '0;
    acc    = '0;
    for (int c = 0; c < NC; c++) begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        acc = acc + BM_W'(c[i] ? s1_d1[i] : s1_d0[i]);
      end
      bm_sum[c*BM_W +: BM_W] = acc;
    end
  end

  // stage 1: lane distances and frame marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d0    <= '0;
      s1_d1    <= '0;
      s1_last  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_d0   <= d0;
        s1_d1   <= d1;
        s1_last <= bus.in_last;
      end
    end
  end

  // stage 2: summed metrics, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_bm    <= '0;
      o_last  <= 1'b0;
    end else if (s1_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_bm   <= bm_sum;
        o_last <= s1_last;
      end
    end
  end

  // symbols accepted in the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt <= '0;
    end else if (in_xfer) begin
      sym_cnt <= bus.in_last ? '0 : sym_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_bmu_soft_pipe.sv
// Randomized bench for bmu_soft_pipe.
// Reference metrics computed from soft values.
module tb_bmu_soft_pipe;
  import vit_pkg::*;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bmu_soft_pipe_if #(.N_OUT(2), .SOFT_W(3)) bus ();
  logic [CW-1:0] sym_cnt;

  bmu_soft_pipe #(
    .N_OUT(2), .SOFT_W(3), .CNT_W(CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .sym_cnt (sym_cnt)
  );

  bmu_soft_pipe_if #(.N_OUT(2), .SOFT_W(1)) hb ();
  logic [CW-1:0] hcnt;

  bmu_soft_pipe #(
    .N_OUT(2), .SOFT_W(1), .CNT_W(CW)
  ) u_hard (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (hb),
    .sym_cnt (hcnt)
  );

  typedef struct {
    logic [15:0] bm;
    logic        last;
    int          edge_n;
  } item_t;

  item_t       q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          mcnt = 0;
  int          edge_n = 0;
  logic        stall_q = 1'b0;
  logic [15:0] held_bm;
  logic        held_last;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bm(
    input logic [5:0] s,
    input logic [1:0] e
  );
    logic [15:0] v;
    int          sum;
    int          r;
    v = '0;
    for (int c = 0; c < 4; c++) begin
      sum = 0;
      for (int i = 0; i < 2; i++) begin
        if (!e[i]) begin
          r = int'(s[i*3 +: 3]);
          sum += ((c >> i) & 1) != 0 ? 7 - r : r;
        end
      end
      v[c*4 +: 4] = 4'(sum);
    end
    return v;
  endfunction

  function automatic logic [7:0] ref_hard(
    input logic [1:0] r
  );
    logic [7:0] v;
    logic [1:0] cw;
    v = '0;
    for (int c = 0; c < 4; c++) begin
      cw = 2'(c);
      v[c*2 +: 2] = 2'($countones(cw ^ r));
    end
    return v;
  endfunction

  task automatic step(
    input logic       v,
    input logic [5:0] s,
    input logic       l,
    input logic [1:0] e,
    input logic       ordy
  );
    item_t      it;
    logic [1:0] ee;
    logic       ov;
`ifdef BMU_ERASURE_EN
    ee = e;
`else
    ee = e & 2'b00;
`endif
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_sym    = s;
    bus.in_last   = l;
    bus.out_ready = ordy;
`ifdef BMU_ERASURE_EN
    bus.in_erase  = ee;
`endif
    #1;
    ov = q.size() > 0 && edge_n - q[0].edge_n >= 2;
    check("sym_cnt", 32'(sym_cnt), 32'(mcnt));
    check("out_valid", 32'(bus.out_valid), 32'(ov));
    check("in_ready", 32'(bus.in_ready),
          32'(q.size() < 2 || ordy));
    if (stall_q && bus.out_valid) begin
      check("hold_bm", 32'(bus.out_bm), 32'(held_bm));
      check("hold_last", 32'(bus.out_last),
            32'(held_last));
    end
    if (bus.out_valid && ordy && q.size() > 0) begin
      check("bm", 32'(bus.out_bm), 32'(q[0].bm));
      check("last", 32'(bus.out_last), 32'(q[0].last));
      void'(q.pop_front());
    end
    stall_q   = bus.out_valid && !ordy;
    held_bm   = bus.out_bm;
    held_last = bus.out_last;
    if (v && bus.in_ready) begin
      it.bm     = ref_bm(s, ee);
      it.last   = l;
      it.edge_n = edge_n;
      q.push_back(it);
      mcnt = l ? 0 : (mcnt + 1) % 65536;
    end
    @(posedge clk);
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, '0, 0, '0, 1);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_sym_cnt", 32'(sym_cnt), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_bm", 32'(bus.out_bm), 0);
    q.delete();
    mcnt    = 0;
    stall_q = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic hard_sym(input logic [1:0] r);
    @(negedge clk);
    hb.in_valid  = 1'b1;
    hb.in_sym    = r;
    hb.out_ready = 1'b1;
    #1;
    check("h_in_ready", 32'(hb.in_ready), 1);
    @(negedge clk);
    hb.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("h_valid", 32'(hb.out_valid), 1);
    check("h_bm", 32'(hb.out_bm), 32'(ref_hard(r)));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sym    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    hb.in_valid   = 1'b0;
    hb.in_sym     = '0;
    hb.in_last    = 1'b0;
    hb.out_ready  = 1'b0;
`ifdef BMU_ERASURE_EN
    bus.in_erase  = '0;
    hb.in_erase   = '0;
`endif
    #12;
    check("r_out_valid", 32'(bus.out_valid), 0);
    check("r_out_bm", 32'(bus.out_bm), 0);
    check("r_out_last", 32'(bus.out_last), 0);
    check("r_sym_cnt", 32'(sym_cnt), 0);
    check("r_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, {3'd7, 3'd0}, 0, 2'b00, 1);
    idle(2);
    check("t1_bm", 32'(bus.out_bm), 32'h70E7);
    check("t1_cnt", 32'(sym_cnt), 1);
    idle(2);

    for (int k = 0; k < 8; k++)
      step(1, 6'($urandom), 0, '0, !(k >= 2 && k <= 4));
    idle(4);
    check("t3_drained", 32'(q.size()), 0);

    for (int k = 0; k < 6; k++)
      step(1, 6'($urandom), k == 4, '0, 1);
    idle(3);
    check("t4_cnt", 32'(sym_cnt), 1);

    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, 6'($urandom),
           $urandom_range(0, 7) == 0, 2'($urandom),
           $urandom_range(0, 3) != 0);
    idle(4);

`ifdef BMU_ERASURE_EN
    step(1, {3'd7, 3'd0}, 0, 2'b10, 1);
    idle(2);
    check("t5_bm_e10", 32'(bus.out_bm), 32'h7070);
    step(1, {3'd7, 3'd0}, 0, 2'b11, 1);
    idle(2);
    check("t5_bm_e11", 32'(bus.out_bm), 0);
`endif

    step(1, 6'($urandom), 0, '0, 1);
    step(1, 6'($urandom), 0, '0, 1);
    async_reset();
    idle(4);

    for (int r = 0; r < 4; r++) hard_sym(2'(r));
    hard_sym(2'b10);
    check("h_bm_10", 32'(hb.out_bm), 32'h49);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
